// File: rtl/queue_pkg.sv
// Shared constants, types and helpers for the priority queue controller.
// Defaults match a two-class, 100-ticket session.
package queue_pkg;

    localparam int DEF_MAX_CLIENTS  = 100;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_CNT_W        = 7;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // Index width for n distinct values, never below one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/class_counter.sv
// Per-class issued/served/skip bookkeeping.
// Issued saturates at MAX_CLIENTS; skip count saturates at STARVE_LIMIT.
module class_counter
    import queue_pkg::*;
#(
    parameter int MAX_CLIENTS  = DEF_MAX_CLIENTS,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc_new,
    input  logic             inc_served,
    input  logic             bypassed,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] served,
    output logic [CNT_W-1:0] waiting,
    output logic             full,
    output logic             starved,
    output logic             drop_req
);

    localparam int K_W = width_of(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CLIENTS);
    localparam logic [K_W-1:0]   K_MAX = K_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] i_q, i_d, s_q, s_d;
    logic [K_W-1:0]   k_q, k_d;

    assign issued   = i_q;
    assign served   = s_q;
    assign waiting  = i_q - s_q;
    assign full     = (i_q == MAX_C);
    assign starved  = (waiting != '0) && (k_q == K_MAX);
    assign drop_req = inc_new && full;

    // Next-state: clear wins, then arrival, service and aging.
    always_comb begin
        i_d = i_q;
        s_d = s_q;
        k_d = k_q;
        if (clear) begin
            i_d = '0;
            s_d = '0;
            k_d = '0;
        end else begin
            if (inc_new && !full)
                i_d = i_q + CNT_W'(1);
            if (inc_served) begin
                s_d = s_q + CNT_W'(1);
                k_d = '0;
            end else if (bypassed && (k_q != K_MAX)) begin
                k_d = k_q + K_W'(1);
            end
            if (i_d == s_d)
                k_d = '0;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            s_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            s_q <= s_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/priority_queue_ctrl.sv
// Multi-class ticket controller: per-class counters plus an
// aging arbiter that serves the highest-priority waiting class.
module priority_queue_ctrl
    import queue_pkg::*;
#(
    parameter int NUM_CLASSES  = 2,
    parameter int MAX_CLIENTS  = DEF_MAX_CLIENTS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int CLS_W        = 1,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                         Clk,
    input  logic                         Reset_N,
    input  logic [NUM_CLASSES-1:0]       New,
    input  logic                         Done,
    input  logic                         Clear,
    output logic [CNT_W-1:0]             Current_Client,
    output logic [CLS_W-1:0]             Current_Class,
    output logic                         Served_Valid,
    output logic [NUM_CLASSES*CNT_W-1:0] Total_Clients,
    output logic [NUM_CLASSES*CNT_W-1:0] Waiting,
    output logic [NUM_CLASSES-1:0]       Full,
    output logic                         Empty,
    output logic                         Drop
);

    logic [CNT_W-1:0]       served [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] eligible, starved, drop_req;
    logic [CLS_W-1:0]       sel;
    logic [CNT_W-1:0]       sel_served;
    logic                   found, accept;

    logic [CNT_W-1:0] cli_q, cli_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic             sv_q, sv_d, drop_q, drop_d;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
        logic [CNT_W-1:0] w;
        assign eligible[c] = (w != '0);
        assign Waiting[c*CNT_W +: CNT_W] = w;

        class_counter #(
            .MAX_CLIENTS  (MAX_CLIENTS),
            .STARVE_LIMIT (STARVE_LIMIT),
            .CNT_W        (CNT_W)
        ) u_cnt (
            .clk        (Clk),
            .rst_n      (Reset_N),
            .clear      (Clear),
            .inc_new    (New[c]),
            .inc_served (accept && (sel == CLS_W'(c))),
            .bypassed   (accept && eligible[c] && (sel != CLS_W'(c))),
            .issued     (Total_Clients[c*CNT_W +: CNT_W]),
            .served     (served[c]),
            .waiting    (w),
            .full       (Full[c]),
            .starved    (starved[c]),
            .drop_req   (drop_req[c])
        );
    end

    assign Empty  = ~|eligible;
    assign accept = Done && !Clear && |eligible;

    // Arbiter: lowest starved class if any, else lowest waiting class.
    always_comb begin
        sel        = '0;
        sel_served = '0;
        found      = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (!found && ((|starved) ? starved[c] : eligible[c])) begin
                sel        = CLS_W'(c);
                sel_served = served[c];
                found      = 1'b1;
            end
        end
    end

    // Output next-state: ticket display holds unless a serve is accepted.
    always_comb begin
        cli_d  = cli_q;
        cls_d  = cls_q;
        sv_d   = accept;
        drop_d = !Clear && |drop_req;
        if (accept) begin
            cli_d = sel_served + CNT_W'(1);
            cls_d = sel;
        end
    end

    // Output registers.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cli_q  <= '0;
            cls_q  <= '0;
            sv_q   <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            cli_q  <= cli_d;
            cls_q  <= cls_d;
            sv_q   <= sv_d;
            drop_q <= drop_d;
        end
    end

    assign Current_Client = cli_q;
    assign Current_Class  = cls_q;
    assign Served_Valid   = sv_q;
    assign Drop           = drop_q;

endmodule

// File: doc/priority_queue_ctrl.md
Name: priority_queue_ctrl

Overview:
- Synchronous, parametrised successor to the single-class ticket counter.
- Issues tickets across NUM_CLASSES priority classes, each with its own session capacity.
- On each service request, serves the highest-priority waiting class; an aging rule prevents starvation of lower classes.
- Sits between customer-arrival inputs and the service-desk display/dispatcher logic.

Parameters:
- NUM_CLASSES, 2, number of priority classes; class 0 is highest priority.
- MAX_CLIENTS, 100, tickets issuable per class per session.
- CNT_W, 7, counter width; must satisfy 2**CNT_W > MAX_CLIENTS.
- CLS_W, 1, class index width; equals max(1, clog2(NUM_CLASSES)).
- STARVE_LIMIT, 4, number of consecutive times a waiting class may be bypassed before it is forced.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_N  input  1  asynchronous, active-low reset.
- New  input  NUM_CLASSES  per-class arrival request, sampled each cycle; several classes may be set in one cycle.
- Done  input  1  service request, sampled each cycle.
- Clear  input  1  synchronous session clear.
- Current_Client  output  CNT_W  ticket number last served, within its class.
- Current_Class  output  CLS_W  class of last served ticket.
- Served_Valid  output  1  one-cycle pulse marking an accepted Done.
- Total_Clients  output  NUM_CLASSES*CNT_W  packed issued count per class; class c at [c*CNT_W +: CNT_W].
- Waiting  output  NUM_CLASSES*CNT_W  packed (issued - served) per class.
- Full  output  NUM_CLASSES  class issued count == MAX_CLIENTS.
- Empty  output  1  no class has waiting > 0.
- Drop  output  1  one-cycle pulse: a New arrived at a Full class.

Behaviour:
- Per-class registers:
  - I[c] issued, range 0..MAX_CLIENTS.
  - S[c] served, invariant S[c] <= I[c].
  - K[c] skip counter, range 0..STARVE_LIMIT.
- Reset (Reset_N low, asynchronous) clears all of I, S, K, plus Current_Client, Current_Class, Served_Valid and Drop.
  - Derived outputs after reset: Empty = 1, Full = 0, Total_Clients = 0, Waiting = 0.
- Reset may assert at any cycle, including mid-session; its effect is immediate and overrides everything else.
- Clear has priority over New and Done in the same cycle. It zeroes I, S and K and suppresses Served_Valid and Drop; Current_Client and Current_Class hold.
- Arrival, for each c with New[c] = 1:
  - If I[c] < MAX_CLIENTS, then I[c] += 1.
  - Otherwise I[c] holds and Drop = 1 in the next cycle.
  - Drop is a single pulse regardless of how many classes overflow in that cycle.
- Service selection on Done = 1 uses pre-edge register values.
  - Eligible class: W[c] = I[c] - S[c] > 0.
  - If any eligible c has K[c] == STARVE_LIMIT, pick the lowest-index such c.
  - Otherwise pick the lowest-index eligible c.
  - If no class is eligible, Done is ignored: no state change, Served_Valid = 0.
- Service update for selected class s:
  - S[s] += 1.
  - Current_Client <= S[s] + 1, i.e. 1-based ticket number.
  - Current_Class <= s.
  - Served_Valid = 1 for exactly one cycle.
  - Latency: all of these are visible on the cycle after the Done edge.
- Aging on an accepted Done:
  - K[s] <= 0.
  - Every other eligible c has K[c] incremented, saturating at STARVE_LIMIT.
  - Any class with W == 0 after the update has K <= 0.
- New[c] and Done serving c in the same cycle both take effect. A Done sampled while W[c] was 0 cannot serve a same-cycle arrival.
- Full, Empty, Waiting and Total_Clients are combinational from registers. No wrap-around is possible: I saturates and S is bounded by I.

Decomposition:
- queue_pkg holds:
  - default constants DEF_MAX_CLIENTS = 100 and DEF_STARVE_LIMIT = 4;
  - a clog2-based width helper function;
  - the typedef cnt_t = logic [CNT_W-1:0].
- Sub-module class_counter, instantiated once per class:
  - owns I, S and K for its class;
  - inputs: inc_new, inc_served, bypassed, clear;
  - outputs: waiting, full, starved, drop_req.
- The top level contains the selection arbiter and the output registers.

Test Plan:
- Reset then New = 2'b01 for 3 cycles, then Done ×3 -> Total_Clients[0] = 3; Current_Client = 1, 2, 3 with Current_Class = 0; Served_Valid on 3 cycles; Empty = 1 at end.
- Load class0 = 10 and class1 = 2, STARVE_LIMIT = 4, then Done ×6 -> served classes 0, 0, 0, 0, 1, 0; Current_Client for the class-1 serve = 1.
- Issue 100 New to class 1, then one more -> Full[1] = 1; I[1] stays 100; Drop pulses exactly once.
- Done with all classes empty -> no Served_Valid; Current_Client and Current_Class unchanged. Then New[0] and Done in the same cycle -> I[0] = 1, S[0] = 0; the next Done serves ticket 1.
- Clear asserted with New = 2'b11 and Done = 1 -> all counts 0, no Served_Valid, no Drop; Current_Client holds its prior value.
- Reset_N dropped mid-cycle during a serve -> outputs reach reset values immediately without waiting for Clk; the first serve after release is ticket 1.
